ysyx_23060332_regfile: RTL and testbench
========================================

Name: ysyx_23060332_regfile

Overview:
- General-purpose register file and write-back scoreboard for the NPC.
- Responder end of the decode-stage register interface: serves the two combinational read ports that decode drives (raddr1/raddr2 in, rdata1/rdata2 out).
- Accepts reservations for pending destination registers, and accepts write-back from WBU through a valid/ready handshake.
- Reports read hazards back to decode so a multi-cycle or pipelined core can stall.

Parameters:
- NR_REGS, 32, number of architectural registers; 16 for RV32E builds.
- DATA_W, 32, register width.
- ADDR_W, 5, register address width; must be at least clog2(NR_REGS).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous reset, active low.
- raddr1  in  ADDR_W  read port 1 address.
- raddr2  in  ADDR_W  read port 2 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- rdata2  out  DATA_W  read port 2 data, combinational.
- rd_hazard  out  1  a requested source register is busy.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ready  out  1  reservation accepted this cycle.
- wb_valid  in  1  write-back request.
- wb_ready  out  1  write-back accepted.
- wb_waddr  in  ADDR_W  write-back destination.
- wb_wdata  in  DATA_W  write-back data.
- err  out  1  sticky protocol error flag.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
  - Reset clears all registers to 0, all busy bits, and err.
  - During reset and in the first cycle after it: wb_ready=0 and rsv_ready=0.
  - Reset asserted mid-operation discards every pending reservation; no late write-back is honoured.
- Reads (zero latency):
  - rdata = reg[raddr].
  - raddr=0 returns 0.
  - raddr >= NR_REGS returns 0.
  - Write-through bypass: if wb_valid && wb_ready && wb_waddr==raddr && raddr!=0 in the same cycle, rdata = wb_wdata.
- Hazard:
  - rd_hazard = (busy[raddr1] && raddr1!=0) || (busy[raddr2] && raddr2!=0).
  - A register being cleared by a write-back in the same cycle does not count as busy (bypass covers it).
  - Decode drives raddr=0 for unused ports, so unused ports never cause a hazard.
- Reservation:
  - rsv_ready=1 unless busy[rsv_addr] is set and not being cleared this cycle.
  - Only one outstanding writer per register is allowed; a second reservation of the same register stalls.
  - A transfer occurs when rsv_valid && rsv_ready.
  - A transfer to rsv_addr=0 or an out-of-range address completes but sets no busy bit.
- Write-back:
  - wb_ready=1 whenever out of reset.
  - On wb_valid && wb_ready: reg[wb_waddr] <= wb_wdata and busy[wb_waddr] is cleared at the clock edge.
  - Writes to x0 or out-of-range addresses are dropped.
  - Write-back to a register that is not busy still writes, and sets err.
- Simultaneous events:
  - Reservation and write-back to the same address in one cycle: the write lands and busy ends up 1 (the clear applies first, then the set).
  - A read of that address in the same cycle gets the bypassed data and rd_hazard=0 for that source.
- err:
  - Set by an out-of-range address on any handshaked port, or by write-back to a non-busy register (x0 excluded).
  - Cleared only by reset.
- State machine: per-register busy bit, 2 states.
  - IDLE -> PENDING on an accepted reservation.
  - PENDING -> IDLE on an accepted write-back.
  - PENDING -> PENDING when both happen in the same cycle.

Decomposition:
- Shared define file: add RegNum, RegDataBus, RegAddrBus, ZeroReg, WriteEnable/WriteDisable, plus a new ScoreboardBus width macro.
- Natural sub-module: ysyx_23060332_scoreboard, holding the busy vector, rsv_ready, rd_hazard and err logic.
- The top level keeps the storage array and the bypass muxes.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then read all addresses -> every rdata=0, wb_ready=0 during reset, err=0.
- Basic write/read: reserve x5, then write-back x5=0xDEADBEEF -> the next cycle raddr1=5 gives 0xDEADBEEF, rd_hazard=0.
- Hazard and bypass:
  - Reserve x7, then raddr2=7 with no write-back -> rd_hazard=1.
  - In the cycle the write-back of x7=0x1234 arrives -> rdata2=0x1234, rd_hazard=0.
- x0 handling: reserve x0, then write-back x0=0xFFFFFFFF -> rdata1 at raddr1=0 is 0, no busy bit set, err=0.
- Double reservation and simultaneous events:
  - Reserve x3, then reserve x3 again -> rsv_ready=0 until the x3 write-back.
  - Write-back x3 and reserve x3 in the same cycle -> busy[3]=1, data written.
- Error paths:
  - Write-back x9 with no reservation -> data written, err=1 and held.
  - With NR_REGS=16, read address 20 -> rdata=0.
  - Apply rst_n=0 with x4 pending -> busy and err cleared, x4 reads 0.

Source files
------------

// File: rtl/ysyx_23060332_regfile_pkg.sv
// ysyx_23060332_regfile_pkg
//   Shared sizing constants, the per-register busy state type and
//   address-classification helpers for the register file and its
//   write-back scoreboard.
package ysyx_23060332_regfile_pkg;

   localparam int   REG_NUM       = 32;   // 16 for RV32E builds
   localparam int   REG_DATA_W    = 32;
   localparam int   REG_ADDR_W    = 5;
   localparam int   SCOREBOARD_W  = REG_NUM;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   // One writer in flight per register: a busy bit is a two-state FSM.
   typedef enum logic {
      BUSY_IDLE    = 1'b0,
      BUSY_PENDING = 1'b1
   } busy_state_e;

   // Address names an implemented register (x0 included).
   function automatic logic addr_in_range(input int addr, input int nr_regs);
      return (addr >= 0) && (addr < nr_regs);
   endfunction

   // Address names a writable, trackable register (x0 excluded).
   function automatic logic addr_is_gpr(input int addr, input int nr_regs);
      return (addr != 0) && (addr < nr_regs);
   endfunction

endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// ysyx_23060332_scoreboard
//   Busy tracking for pending destination registers.
//   Ports:
//     clk, rst_n          core clock, synchronous active-low reset
//     raddr1, raddr2      decode source addresses (hazard lookup)
//     rsv_valid/addr      destination reservation request
//     rsv_ready           reservation accepted this cycle
//     wb_valid, wb_waddr  write-back request / destination
//     wb_ready            write-back accepted (0 in reset and the cycle after)
//     rd_hazard           a requested source is still pending
//     err                 sticky protocol error
module ysyx_23060332_scoreboard
   import ysyx_23060332_regfile_pkg::*;
#(
   parameter int NR_REGS = REG_NUM,
   parameter int ADDR_W  = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ready,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_waddr,
   output logic              wb_ready,
   output logic              rd_hazard,
   output logic              err
);

   logic               ready_q;
   logic               err_q;
   logic               err_d;
   logic               wb_fire;
   logic               rsv_fire;
   logic [NR_REGS-1:0] busy;
   logic [NR_REGS-1:0] busy_eff;
   busy_state_e        state_q [NR_REGS];
   busy_state_e        state_d [NR_REGS];

   // Select the bit of a per-register vector for an address; any
   // out-of-range address simply matches nothing and yields 0.
   function automatic logic pick(input logic [NR_REGS-1:0] vec,
                                 input logic [ADDR_W-1:0]  addr);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NR_REGS; i++)
         if (addr == ADDR_W'(i)) hit = vec[i];
      return hit;
   endfunction

   // ready_q is low in the first cycle after reset; rst_n gates it
   // combinationally so nothing is accepted while reset is applied.
   assign wb_ready = ready_q & rst_n;
   assign wb_fire  = wb_valid & wb_ready;

   always_comb begin
      for (int i = 0; i < NR_REGS; i++)
         busy[i] = (state_q[i] == BUSY_PENDING);
   end

   // A register cleared by this cycle's write-back is no longer busy:
   // the bypass mux supplies its value.
   always_comb begin
      for (int i = 0; i < NR_REGS; i++)
         busy_eff[i] = busy[i] & ~(wb_fire && (wb_waddr == ADDR_W'(i)));
   end

   assign rsv_ready = wb_ready & ~pick(busy_eff, rsv_addr);
   assign rsv_fire  = rsv_valid & rsv_ready;

   assign rd_hazard = ((raddr1 != '0) && pick(busy_eff, raddr1)) ||
                      ((raddr2 != '0) && pick(busy_eff, raddr2));

   // Clear first, then set: a same-cycle write-back and reservation of
   // one register leaves it PENDING for the new writer.
   always_comb begin
      for (int i = 0; i < NR_REGS; i++) begin
         // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
         state_d[i] = state_q[i];
         if (wb_fire && (wb_waddr == ADDR_W'(i)))
            state_d[i] = BUSY_IDLE;
         if (rsv_fire && (rsv_addr == ADDR_W'(i)) && (i != 0))
            state_d[i] = BUSY_PENDING;
      end
   end

   assign err_d = err_q
                | (rsv_fire & ~addr_in_range(int'(rsv_addr), NR_REGS))
                | (wb_fire  & ~addr_in_range(int'(wb_waddr), NR_REGS))
                | (wb_fire  &  addr_is_gpr(int'(wb_waddr), NR_REGS)
                            & ~pick(busy, wb_waddr));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NR_REGS; i++) state_q[i] <= BUSY_IDLE;
      end else begin
         ready_q <= 1'b1;
         err_q   <= err_d;
         for (int i = 0; i < NR_REGS; i++) state_q[i] <= state_d[i];
      end
   end

   assign err = err_q;

endmodule

// File: rtl/ysyx_23060332_regfile.sv
// ysyx_23060332_regfile
//   NPC general-purpose register file with write-back scoreboard.
//   Ports:
//     clk, rst_n           core clock, synchronous active-low reset
//     raddr1/2, rdata1/2   combinational read ports (x0 and out-of-range read 0,
//                          same-cycle write-back is bypassed)
//     rd_hazard            a requested source register is pending
//     rsv_valid/addr/ready destination reservation handshake
//     wb_valid/ready       write-back handshake; wb_waddr/wb_wdata payload
//     err                  sticky protocol error
module ysyx_23060332_regfile
   import ysyx_23060332_regfile_pkg::*;
#(
   parameter int NR_REGS = REG_NUM,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              rd_hazard,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ready,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   output logic              err
);

   localparam int IDX_W = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;

   logic [DATA_W-1:0] regs_q [NR_REGS];
   logic              wb_we;

   ysyx_23060332_scoreboard #(
      .NR_REGS (NR_REGS),
      .ADDR_W  (ADDR_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr1    (raddr1),
      .raddr2    (raddr2),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .wb_valid  (wb_valid),
      .wb_waddr  (wb_waddr),
      .wb_ready  (wb_ready),
      .rd_hazard (rd_hazard),
      .err       (err)
   );

   // Accepted write-backs to x0 or beyond NR_REGS are dropped here.
   assign wb_we = (wb_valid && wb_ready && addr_is_gpr(int'(wb_waddr), NR_REGS))
                ? WRITE_ENABLE : WRITE_DISABLE;

   always_ff @(posedge clk) begin
      // NOTE: the architectural registers must read 0 after reset, so this storage is reset explicitly rather than left as plain RAM.
      if (!rst_n) begin
         for (int i = 0; i < NR_REGS; i++) regs_q[i] <= '0;
      end else if (wb_we) begin
         regs_q[wb_waddr[IDX_W-1:0]] <= wb_wdata;
      end
   end

   assign rdata1 = !addr_is_gpr(int'(raddr1), NR_REGS) ? '0
                 : (wb_we && (wb_waddr == raddr1)) ? wb_wdata
                 : regs_q[raddr1[IDX_W-1:0]];

   assign rdata2 = !addr_is_gpr(int'(raddr2), NR_REGS) ? '0
                 : (wb_we && (wb_waddr == raddr2)) ? wb_wdata
                 : regs_q[raddr2[IDX_W-1:0]];

endmodule

// File: tb/tb_ysyx_23060332_regfile.sv
// tb_ysyx_23060332_regfile
//   Directed scenarios followed by randomized traffic on an RV32E-sized
//   instance (16 registers, 5-bit addresses), checked every cycle
//   against a register/busy/err model built from the block's rules.
module tb_ysyx_23060332_regfile;

   localparam int NR = 16;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] raddr1, raddr2, rsv_addr, wb_waddr;
   logic [DW-1:0] rdata1, rdata2, wb_wdata;
   logic          rd_hazard, rsv_valid, rsv_ready, wb_valid, wb_ready, err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_no  = 0;

   // Reference state: register values, pending flags, sticky error and
   // the number of clock edges seen since reset was last sampled.
   logic [31:0] m_reg  [32];
   bit          m_busy [32];
   bit          m_err;
   int          m_cnt;

   always #5 clk = ~clk;

   ysyx_23060332_regfile #(
      .NR_REGS (NR),
      .DATA_W  (DW),
      .ADDR_W  (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr1    (raddr1),
      .raddr2    (raddr2),
      .rdata1    (rdata1),
      .rdata2    (rdata2),
      .rd_hazard (rd_hazard),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc_no, got, exp);
      end
   endtask

   function automatic bit gpr(input int a);
      return (a != 0) && (a < NR);
   endfunction

   function automatic bit exp_ready();
      return (rst_n === 1'b1) && (m_cnt >= 1);
   endfunction

   function automatic bit exp_wb_write();
      return wb_valid && exp_ready() && gpr(int'(wb_waddr));
   endfunction

   function automatic bit exp_busy_now(input logic [AW-1:0] a);
      return m_busy[a] && !(exp_wb_write() && wb_waddr == a);
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a);
      if (!gpr(int'(a)))                    return 32'h0;
      if (exp_wb_write() && wb_waddr == a)  return wb_wdata;
      return m_reg[a];
   endfunction

   function automatic bit exp_rsv_ready();
      return exp_ready() && !exp_busy_now(rsv_addr);
   endfunction

   function automatic bit exp_hazard();
      return (raddr1 != 0 && exp_busy_now(raddr1)) || (raddr2 != 0 && exp_busy_now(raddr2));
   endfunction

   task automatic drive(input logic r, input logic rv, input logic [AW-1:0] ra,
                        input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      rst_n = r;  rsv_valid = rv; rsv_addr = ra;
      wb_valid = wv; wb_waddr = wa; wb_wdata = wd;
      raddr1 = a1; raddr2 = a2;
   endtask

   // Compare every output against the model on the falling edge.
   task automatic sample();
      @(negedge clk);
      check("rdata1",    rdata1,           exp_rdata(raddr1));
      check("rdata2",    rdata2,           exp_rdata(raddr2));
      check("rd_hazard", 32'(rd_hazard),   32'(exp_hazard()));
      check("rsv_ready", 32'(rsv_ready),   32'(exp_rsv_ready()));
      check("wb_ready",  32'(wb_ready),    32'(exp_ready()));
      check("err",       32'(err),         32'(m_err));
   endtask

   // Advance the model by one rising edge, then settle 1 time unit after it.
   task automatic tick();
      bit rf, wf;
      @(posedge clk);
      if (rst_n !== 1'b1) begin
         for (int i = 0; i < 32; i++) begin m_reg[i] = 32'h0; m_busy[i] = 0; end
         m_err = 0;
         m_cnt = 0;
      end else begin
         rf = rsv_valid && exp_rsv_ready();
         wf = wb_valid && exp_ready();
         if (wf && int'(wb_waddr) >= NR) m_err = 1;
         if (wf && gpr(int'(wb_waddr))) begin
            if (!m_busy[wb_waddr]) m_err = 1;
            m_reg[wb_waddr]  = wb_wdata;
            m_busy[wb_waddr] = 0;
         end
         if (rf) begin
            if (int'(rsv_addr) >= NR)   m_err = 1;
            else if (rsv_addr != 0)     m_busy[rsv_addr] = 1;
         end
         m_cnt++;
      end
      cyc_no++;
      #1;
   endtask

   task automatic step(input logic r, input logic rv, input logic [AW-1:0] ra,
                       input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      drive(r, rv, ra, wv, wa, wd, a1, a2);
      sample();
      tick();
   endtask

   initial begin
      logic          r_rst, r_rv, r_wv;
      logic [AW-1:0] r_ra, r_wa, r_a1, r_a2;

      for (int i = 0; i < 32; i++) begin m_reg[i] = 32'h0; m_busy[i] = 0; end
      m_err = 0;
      m_cnt = 0;

      // Reset held for two edges; outputs quiet while it is applied.
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      drive(1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 32'h1111, 5'd1, 5'd2);
      sample();
      check("wb_ready_in_reset",  32'(wb_ready),  32'h0);
      check("rsv_ready_in_reset", 32'(rsv_ready), 32'h0);
      tick();

      // First cycle after reset: a write-back offered now must be ignored.
      drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 32'h5555, 5'd0, 5'd0);
      sample();
      check("wb_ready_first_cycle", 32'(wb_ready), 32'h0);
      tick();

      for (int a = 0; a < 32; a += 2) step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1));
      check("err_after_reset", 32'(err), 32'h0);

      // Reserve x5, write it back, read it.
      step(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd2);
      sample();
      check("x5_read",   rdata1,          32'hDEADBEEF);
      check("x5_hazard", 32'(rd_hazard),  32'h0);
      check("x2_dropped_before_ready", rdata2, 32'h0);
      tick();

      // Hazard on x7, then bypass when the write-back arrives.
      step(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
      sample();
      check("x7_hazard", 32'(rd_hazard), 32'h1);
      tick();
      drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234, 5'd0, 5'd7);
      sample();
      check("x7_bypass",        rdata2,         32'h1234);
      check("x7_bypass_hazard", 32'(rd_hazard), 32'h0);
      tick();

      // x0: reservation sets nothing, write-back dropped without error.
      step(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      sample();
      check("x0_read",      rdata1,         32'h0);
      check("x0_err",       32'(err),       32'h0);
      check("x0_rsv_ready", 32'(rsv_ready), 32'h1);
      tick();

      // Double reservation of x3 stalls until its write-back.
      step(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
         sample();
         check("x3_double_rsv", 32'(rsv_ready), 32'h0);
         tick();
      end
      drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 32'h000000A5, 5'd0, 5'd0);
      sample();
      check("x3_rsv_with_wb", 32'(rsv_ready), 32'h1);
      tick();
      drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      sample();
      check("x3_data",        rdata1,         32'h000000A5);
      check("x3_still_busy",  32'(rd_hazard), 32'h1);
      check("x3_rsv_blocked", 32'(rsv_ready), 32'h0);
      tick();
      step(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h77, 5'd3, 5'd0);

      // Unreserved write-back to x9 writes and sets a sticky error.
      step(1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd20);
         sample();
         check("x9_data",     rdata1,   32'h99);
         check("x9_err_held", 32'(err), 32'h1);
         check("oor_read",    rdata2,   32'h0);
         tick();
      end

      // Reset with x4 pending and a write-back to it in the reset cycle.
      step(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'hBAD0BAD0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      drive(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd4, 5'd5);
      sample();
      check("x4_after_reset",    rdata1,         32'h0);
      check("x5_after_reset",    rdata2,         32'h0);
      check("x4_not_busy",       32'(rsv_ready), 32'h1);
      check("err_cleared",       32'(err),       32'h0);
      tick();

      // Out-of-range reservation completes and sets err.
      step(1'b1, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      sample();
      check("oor_rsv_err", 32'(err), 32'h1);
      tick();

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 1500; n++) begin
         r_rst = ($urandom_range(0, 79) != 0);
         r_rv  = 1'($urandom_range(0, 1));
         r_wv  = 1'($urandom_range(0, 1));
         r_ra  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
         r_wa  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
         r_a1  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 17));
         r_a2  = ($urandom_range(0, 3) == 0) ? r_ra : 5'($urandom_range(0, 17));
         step(r_rst, r_rv, r_ra, r_wv, r_wa, 32'($urandom), r_a1, r_a2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
